// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, register file geometry and writeback requester indices.
package cpu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREG       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_LSU = 1;
  localparam int unsigned WB_MDU = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-input arbiter producing a one-hot grant; round-robin by default, fixed priority
// (input 0 highest) when WB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  // Nothing is granted while reset is held.
  logic [N-1:0] req_m;
  assign req_m = req_i & {N{~reset_i}};

`ifdef WB_FIXED_PRIO_EN

  always_comb begin
    gnt_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_m[i] && (gnt_o == '0)) begin
        gnt_o[i] = 1'b1;
      end
    end
  end

`else

  localparam int unsigned PtrW = $clog2(N);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] win;
  logic            found;
  int unsigned     idx;

  // Search starts at the pointer and wraps; the pointer then moves just past the winner.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req_m[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
        win        = PtrW'(idx);
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (win == PtrW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port owner: arbitrates writeback producers into a registered write
// command and tracks pending long-latency destinations for RAW stalls. See WB_FIXED_PRIO_EN.
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*5-1:0]      req_rd_i,
  input  logic [N_REQ*XLEN-1:0]   req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic                    iss_valid_i,
  input  logic [REG_ADDR_W-1:0]   iss_rd_i,
  input  logic [REG_ADDR_W-1:0]   chk_rs1_i,
  input  logic [REG_ADDR_W-1:0]   chk_rs2_i,
  output logic                    stall_o,
  output logic                    wr_en_o,
  output logic [REG_ADDR_W-1:0]   wr_addr_o,
  output logic [XLEN-1:0]         wr_data_o
);

  logic [N_REQ-1:0]      gnt;
  logic                  granted;
  reg_addr_t             rd_sel;
  logic [XLEN-1:0]       data_sel;

  logic                  wr_en_q, wr_en_d;
  reg_addr_t             wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  logic [NREG-1:0]       pending_q, pending_d;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_i   (req_valid_i),
    .gnt_o   (gnt)
  );

  assign req_ready_o = gnt;
  assign granted     = |gnt;

  always_comb begin
    rd_sel   = '0;
    data_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        rd_sel   = rd_sel | req_rd_i[i*5 +: 5];
        data_sel = data_sel | req_data_i[i*XLEN +: XLEN];
      end
    end
  end

  // A granted write to x0 is consumed but never reaches the register file.
  always_comb begin
    wr_en_d   = granted && (rd_sel != '0);
    wr_addr_d = wr_en_d ? rd_sel : wr_addr_q;
    wr_data_d = wr_en_d ? data_sel : wr_data_q;
  end

  // Set after clear so a same-cycle reissue to the written rd stays pending.
  always_comb begin
    pending_d = pending_q;
    if (granted) begin
      pending_d[rd_sel] = 1'b0;
    end
    if (iss_valid_i && (iss_rd_i != '0)) begin
      pending_d[iss_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign stall_o   = pending_q[chk_rs1_i] | pending_q[chk_rs2_i];
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: spec-level model of arbitration and pending
// scoreboard, with expected write commands queued at the grant edge and compared a cycle later.
module tb_regfile_wb_arbiter;
  import cpu_pkg::*;

  localparam int N = 3;
  localparam int W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*5-1:0]    req_rd;
  logic [N*W-1:0]    req_data;
  logic [N-1:0]      req_ready;
  logic              iss_valid;
  logic [4:0]        iss_rd;
  logic [4:0]        chk_rs1;
  logic [4:0]        chk_rs2;
  logic              stall;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [W-1:0]      wr_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .N_REQ (N),
    .XLEN  (W),
    .NREG  (32)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_rd_i    (req_rd),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .chk_rs1_i   (chk_rs1),
    .chk_rs2_i   (chk_rs2),
    .stall_o     (stall),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data)
  );

  typedef struct packed {
    logic         en;
    logic [4:0]   addr;
    logic [W-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mptr     = 0;
  logic [31:0] mpend    = '0;
  int          mwin;
  logic [N-1:0] dut_gnt;

  // Contract tracking: an ungranted valid request must be held unchanged.
  logic [N-1:0]   prv_v   = '0;
  logic [N-1:0]   prv_g   = '0;
  logic [N*5-1:0] prv_rd  = '0;
  logic [N*W-1:0] prv_dat = '0;
  logic           prv_rst = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [W-1:0] d);
    req_valid[i]        = v;
    req_rd[i*5 +: 5]    = rd;
    req_data[i*W +: W]  = d;
  endtask

  // One clock cycle: inputs already driven after a negedge.
  task automatic cycle();
    int         idx;
    logic [N-1:0] exp_rdy;
    logic [4:0] r;
    wr_t        e;
    wr_t        w;
    #1;
    if (!reset && !prv_rst) begin
      for (int i = 0; i < N; i++) begin
        if (prv_v[i] && !prv_g[i]) begin
          assert (req_valid[i] && req_rd[i*5 +: 5] == prv_rd[i*5 +: 5] &&
                  req_data[i*W +: W] == prv_dat[i*W +: W])
            else $error("requester %0d dropped or changed an ungranted request", i);
        end
      end
    end
    mwin = -1;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        idx = (mptr + i) % N;
        if (mwin < 0 && req_valid[idx]) mwin = idx;
      end
    end
    exp_rdy = '0;
    if (mwin >= 0) exp_rdy[mwin] = 1'b1;
    dut_gnt = req_ready;
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    check_eq("stall", 64'(stall), 64'(mpend[chk_rs1] | mpend[chk_rs2]));
    prv_v = req_valid; prv_g = exp_rdy; prv_rd = req_rd; prv_dat = req_data; prv_rst = reset;
    @(posedge clk);
    e = '0;
    if (reset) begin
      mptr  = 0;
      mpend = '0;
    end else begin
      if (mwin >= 0) begin
        r      = req_rd[mwin*5 +: 5];
        e.en   = (r != 5'd0);
        e.addr = r;
        e.data = req_data[mwin*W +: W];
        mpend[r] = 1'b0;
`ifndef WB_FIXED_PRIO_EN
        mptr = (mwin + 1) % N;
`endif
      end
      if (iss_valid && iss_rd != 5'd0) mpend[iss_rd] = 1'b1;
    end
    exp_q.push_back(e);
    #1;
    w = exp_q.pop_front();
    check_eq("wr_en", 64'(wr_en), 64'(w.en));
    if (w.en) begin
      check_eq("wr_addr", 64'(wr_addr), 64'(w.addr));
      check_eq("wr_data", 64'(wr_data), 64'(w.data));
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_rd = '0; req_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
  endtask

  int seq[6];

  initial begin
    reset = 1'b1;
    idle_inputs();
    chk_rs1 = 5'd5; chk_rs2 = 5'd6;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    check_eq("idle_stall", 64'(stall), 64'd0);

    // Single ALU write
    set_req(WB_ALU, 1'b1, 5'd3, 32'hDEADBEEF);
    cycle();
    check_eq("alu_ready", 64'(dut_gnt), 64'd1);
    check_eq("alu_wr_addr", 64'(wr_addr), 64'd3);
    idle_inputs();
    cycle();
    check_eq("alu_wr_done", 64'(wr_en), 64'd0);

    // All requesters continuously valid from a fresh pointer
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'hA000_0000 + i);
`ifdef WB_FIXED_PRIO_EN
    seq = '{0, 0, 0, 0, 0, 0};
`else
    seq = '{0, 1, 2, 0, 1, 2};
`endif
    for (int k = 0; k < 6; k++) begin
      cycle();
      check_eq("seq_grant", 64'(dut_gnt), 64'(1) << seq[k]);
      check_eq("seq_wr_addr", 64'(wr_addr), 64'(seq[k] + 1));
    end
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;

    // Scoreboard set / clear / set-wins
    chk_rs1 = 5'd0; chk_rs2 = 5'd7;
    iss_valid = 1'b1; iss_rd = 5'd7;
    cycle();
    iss_valid = 1'b0;
    cycle();
    check_eq("sb_set", 64'(stall), 64'd1);
    set_req(WB_LSU, 1'b1, 5'd7, 32'h0000_7777);
    cycle();
    idle_inputs();
    cycle();
    check_eq("sb_clear", 64'(stall), 64'd0);
    iss_valid = 1'b1; iss_rd = 5'd7;
    cycle();
    set_req(WB_LSU, 1'b1, 5'd7, 32'h0000_7778);
    cycle();
    idle_inputs();
    cycle();
    check_eq("sb_setwins", 64'(stall), 64'd1);
    set_req(WB_LSU, 1'b1, 5'd7, 32'h0000_7779);
    cycle();
    idle_inputs();

    // x0 handling
    set_req(WB_MDU, 1'b1, 5'd0, 32'h0000_1234);
    iss_valid = 1'b1; iss_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    cycle();
    check_eq("x0_ready", 64'(dut_gnt), 64'd4);
    idle_inputs();
    cycle();
    check_eq("x0_wr_en", 64'(wr_en), 64'd0);
    check_eq("x0_stall", 64'(stall), 64'd0);

    // Reset mid-operation: pointer moved, rd 9 pending, LSU valid
    set_req(WB_LSU, 1'b1, 5'd4, 32'h4444);
    iss_valid = 1'b1; iss_rd = 5'd9;
    cycle();
    idle_inputs();
    reset = 1'b1;
    set_req(WB_LSU, 1'b1, 5'd10, 32'hAAAA);
    cycle();
    idle_inputs();
    reset = 1'b0;
    chk_rs1 = 5'd9; chk_rs2 = 5'd0;
    cycle();
    check_eq("rst_wr_en", 64'(wr_en), 64'd0);
    check_eq("rst_pending", 64'(stall), 64'd0);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 20), 32'hB000_0000 + i);
    cycle();
    check_eq("rst_ptr", 64'(dut_gnt), 64'd1);
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;

    // Random traffic honouring the hold-until-granted contract
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
        end
      end
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd    = 5'($urandom_range(0, 31));
      chk_rs1   = 5'($urandom_range(0, 31));
      chk_rs2   = 5'($urandom_range(0, 31));
      cycle();
      if (mwin >= 0) req_valid[mwin] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file. Arbitrates writeback among N_REQ producers: 0 = ALU, 1 = load/store unit, 2 = mul/div.
- Keeps a per-register pending scoreboard so decode can stall on RAW hazards against in-flight long-latency results.
- Output is a registered write command that drives the regfile's write-enable, rd address and rd data inputs directly.

Parameters:
- N_REQ, 3, number of writeback requesters (2..4).
- XLEN, 32, data width.
- NREG, 32, register count; address width is log2(NREG) = 5.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  N_REQ  per-requester writeback request.
- req_rd  in  N_REQ*5  per-requester destination register, packed, requester 0 in LSBs.
- req_data  in  N_REQ*XLEN  per-requester result, packed.
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when valid & ready.
- iss_valid  in  1  decode issues an instruction with a long-latency destination.
- iss_rd  in  5  destination to mark pending.
- chk_rs1  in  5  decode source 1.
- chk_rs2  in  5  decode source 2.
- stall  out  1  combinational: chk_rs1 or chk_rs2 is pending.
- wr_en  out  1  registered regfile write enable.
- wr_addr  out  5  registered regfile rd address.
- wr_data  out  XLEN  registered regfile rd data.

Behaviour:
- Reset: wr_en=0, wr_addr=0, wr_data=0, all pending bits=0, RR pointer=0. Reset mid-operation drops all requests; wr_en=0 on the following cycle. req_ready is 0 while reset=1.
- Arbitration: combinational; at most one req_ready high per cycle, only to a valid requester. The write port accepts one result every cycle, so grant = ready with no backpressure beyond losing arbitration.
- Round-robin:
  - Search starts at the pointer and wraps modulo N_REQ.
  - On a grant, the pointer becomes winner+1 mod N_REQ.
  - No grant leaves the pointer unchanged.
- Requester contract: a requester must hold valid, rd and data stable until granted. The bench asserts this.
- Write latency: a grant in cycle T gives wr_en=1, wr_addr=req_rd, wr_data=req_data in cycle T+1. With no grant, wr_en=0 and wr_addr/wr_data hold.
- x0: a granted request with rd=0 is consumed (ready=1) but produces wr_en=0. x0 is never marked pending; iss_rd=0 is ignored.
- Scoreboard:
  - Pending bit set on iss_valid at the next edge.
  - Pending bit cleared when a granted write to that rd occurs (cleared at the grant edge, same edge the write is registered).
  - Simultaneous set and clear of the same rd: set wins (a newer producer is in flight).
- stall = pending[chk_rs1] | pending[chk_rs2]. No bypass, so a register cleared in cycle T reads as not pending in T+1, which is when wr_en is high. The regfile writes on negedge, so decode reading in T+1 sees the new value.
- Issuing to an rd that is already pending simply keeps the bit set. Ordering between producers of the same rd is decode's responsibility; decode must stall on a WAW to a pending rd.

Optional Feature:
- WB_FIXED_PRIO_EN defined: fixed priority, requester 0 highest; RR pointer removed.
- WB_FIXED_PRIO_EN undefined: round-robin as above.

Decomposition:
- Shared package (cpu_pkg): XLEN, NREG, REG_ADDR_W=5, requester index constants (WB_ALU=0, WB_LSU=1, WB_MDU=2).
- One sub-module, rr_arbiter (N-input round-robin/fixed arbiter with grant vector and pointer update). The scoreboard stays inline.

Test Plan:
- Reset then idle: wr_en=0, stall=0 for chk_rs1=5, chk_rs2=6; all req_ready=0.
- Single ALU request rd=3, data=0xDEADBEEF in cycle T: req_ready[0]=1 in T; in T+1 wr_en=1, wr_addr=3, wr_data=0xDEADBEEF; the next cycle wr_en=0.
- All three requesters continuously valid (rd=1,2,3) under round-robin: grants go 0,1,2,0,1,2, one write per cycle, wr_addr sequence 1,2,3,1,2,3. With WB_FIXED_PRIO_EN: grant stays on 0 while its valid is held.
- Scoreboard: iss_valid with iss_rd=7; chk_rs2=7 gives stall=1. LSU writes rd=7: stall drops to 0 the cycle after the grant. Same-cycle iss_rd=7 and LSU grant for rd=7: stall remains 1.
- x0: MDU request rd=0, data=0x1234 is granted, wr_en stays 0; iss_rd=0 with chk_rs1=0 gives stall=0.
- Reset asserted while LSU is valid and rd=9 is pending: the next cycle wr_en=0, pending cleared (chk_rs1=9 gives stall=0), RR pointer back to 0.
